// File: rtl/axi4_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and a slave port.
// Signal names match the original flat M_AXI_* ports so existing connections map 1:1.
//   master modport: drives AW*/W*/BREADY, samples AWREADY/WREADY/B*.
//   slave  modport: mirror image of master.
interface axi4_write_master_if #(
    parameter int unsigned P_ID_WIDTH   = 6,
    parameter int unsigned P_ADDR_WIDTH = 32,
    parameter int unsigned P_DATA_WIDTH = 256
);
    logic [P_ID_WIDTH-1:0]     M_AXI_AWID;
    logic [P_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [7:0]                M_AXI_AWLEN;
    logic [2:0]                M_AXI_AWSIZE;
    logic [1:0]                M_AXI_AWBURST;
    logic                      M_AXI_AWVALID;
    logic                      M_AXI_AWREADY;
    logic [P_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [P_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                      M_AXI_WLAST;
    logic                      M_AXI_WVALID;
    logic                      M_AXI_WREADY;
    logic [P_ID_WIDTH-1:0]     M_AXI_BID;
    logic [1:0]                M_AXI_BRESP;
    logic                      M_AXI_BVALID;
    logic                      M_AXI_BREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axi4_write_master.sv
// AXI4 write engine: one request (WRITE_ADDR/WRITE_DATA/WRITE_START) becomes one INCR burst of
// P_WRITE_BURSTS beats on AW/W/B, completion reported by a one-cycle WRITE_DONE (+WRITE_ERROR).
// One transaction outstanding; AW, W and B phases run strictly in sequence.
// Ports:
//   CLOCK, RESET        clock, synchronous active-high reset
//   WRITE_ADDR/DATA     request byte offset (added to base) and beat data, sampled on accept
//   WRITE_START/READY   request handshake; READY only while idle
//   WRITE_DONE/ERROR    completion pulse; ERROR only together with DONE
//   m_axi               AXI4 write channels (master modport)
// Optional feature: define AXI4_WMASTER_INCR_DATA_EN to send latched data + k on beat k;
// otherwise every beat repeats the latched data.
module axi4_write_master #(
    parameter logic [31:0] P_TARGET_SLAVE_BASE_ADDR = 32'h0,
    parameter int unsigned P_WRITE_BURSTS           = 1,
    parameter int unsigned P_AXI_ID                 = 0,
    parameter int unsigned P_ID_WIDTH               = 6,
    parameter int unsigned P_ADDR_WIDTH             = 32,
    parameter int unsigned P_DATA_WIDTH             = 256
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [P_ADDR_WIDTH-1:0] WRITE_ADDR,
    input  logic [P_DATA_WIDTH-1:0] WRITE_DATA,
    input  logic                    WRITE_START,
    output logic                    WRITE_READY,
    output logic                    WRITE_DONE,
    output logic                    WRITE_ERROR,
    axi4_write_master_if.master     m_axi
);
    localparam logic [7:0]            LAST_BEAT   = 8'(P_WRITE_BURSTS - 1);
    localparam logic [31:0]           BURST_BYTES = 32'(P_WRITE_BURSTS * (P_DATA_WIDTH / 8));
    localparam logic [P_ID_WIDTH-1:0] AXI_ID      = P_ID_WIDTH'(P_AXI_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_REJECT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    wlast_q, wlast_d;
    logic                    bready_q, bready_d;
    logic [P_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]              beat_q, beat_d;

    logic [P_ADDR_WIDTH-1:0] accept_addr;
    logic [31:0]             burst_end;
    logic [7:0]              beat_next;
    logic                    bresp_err;

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        done_d    = done_q;
        error_d   = error_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        beat_d    = beat_q;

        accept_addr = P_ADDR_WIDTH'(P_TARGET_SLAVE_BASE_ADDR) + WRITE_ADDR;
        // End offset of the burst within its 4 KB page; beyond 4096 it would cross the boundary.
        burst_end   = 32'(accept_addr[11:0]) + BURST_BYTES;
        beat_next   = beat_q + 8'd1;
        bresp_err   = (m_axi.M_AXI_BRESP inside {2'b10, 2'b11}) || (m_axi.M_AXI_BID != AXI_ID);

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (WRITE_START && ready_q) begin
                    ready_d  = 1'b0;
                    awaddr_d = accept_addr;
                    data_d   = WRITE_DATA;
                    wdata_d  = WRITE_DATA;
                    beat_d   = '0;
                    if (burst_end > 32'd4096) begin
                        state_d = S_REJECT;
                    end else begin
                        awvalid_d = 1'b1;
                        state_d   = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (awvalid_q && m_axi.M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (LAST_BEAT == 8'd0);
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (wvalid_q && m_axi.M_AXI_WREADY) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        beat_d  = beat_next;
                        wlast_d = (beat_next == LAST_BEAT);
`ifdef AXI4_WMASTER_INCR_DATA_EN
                        wdata_d = data_q + P_DATA_WIDTH'(beat_next);
`endif
                    end
                end
            end
            S_RESP: begin
                if (bready_q && m_axi.M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    error_d  = bresp_err;
                    state_d  = S_DONE;
                end
            end
            // Rejected bursts spend one idle-bus cycle here so the error completion
            // lands two cycles after accept.
            S_REJECT: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b0;
                error_d = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            beat_q    <= beat_d;
        end
    end

    assign WRITE_READY         = ready_q;
    assign WRITE_DONE          = done_q;
    assign WRITE_ERROR         = error_q;
    assign m_axi.M_AXI_AWID    = AXI_ID;
    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWLEN   = LAST_BEAT;
    assign m_axi.M_AXI_AWSIZE  = 3'($clog2(P_DATA_WIDTH / 8));
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WLAST   = wlast_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
endmodule
